// File: rtl/vsq_pkg.sv
// vsq_pkg: definitions shared by the VSQ accumulator and output buffer.
//   vsq_state_e     - accumulator control states
//   VSQ_*_W         - default datapath widths
//   round_half_up() - round-half-up right shift, evaluated at 64 bits so the
//                     rounding add cannot wrap for any accumulator below 64 bits
package vsq_pkg;

  localparam int VSQ_PSUM_W = 24;
  localparam int VSQ_ACC_W  = 32;
  localparam int VSQ_OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } vsq_state_e;

  // (s + 2^(sh-1)) >> sh, with no bias when sh == 0
  function automatic logic [63:0] round_half_up(input logic [63:0] s,
                                                input logic [5:0]  sh);
    logic [63:0] bias;
    bias = (sh == 6'd0) ? 64'd0 : (64'd1 << (sh - 6'd1));
    return (s + bias) >> sh;
  endfunction

endpackage

// File: rtl/vsq_round_sat.sv
// vsq_round_sat: combinational round-half-up right shift followed by unsigned
// saturation to OUT_W bits.
// Ports:
//   s     in  ACC_W  unsigned sum to scale
//   shift in  SH_W   right-shift amount
//   r     out OUT_W  rounded, saturated result
//   sat   out 1      r was clamped to all-ones
module vsq_round_sat
  import vsq_pkg::*;
#(
  parameter int ACC_W = VSQ_ACC_W,
  parameter int OUT_W = VSQ_OUT_W,
  parameter int SH_W  = 5
) (
  input  logic [ACC_W-1:0] s,
  input  logic [SH_W-1:0]  shift,
  output logic [OUT_W-1:0] r,
  output logic             sat
);

  logic [63:0] rounded;

  always_comb begin
    rounded = round_half_up(64'(s), 6'(shift));
    sat     = |rounded[63:OUT_W];
    r       = sat ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
  end

endmodule

// File: rtl/vsq_accumulator.sv
// vsq_accumulator: accumulates vec_count scaled partial sums from the VSQ
// stage, then rounds/shifts/saturates the total and offers it downstream.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, vec_count,   run request from the layer sequencer; count and
//   shift               shift are latched when the start is accepted
//   in_valid/in_ready/  partial-sum input handshake
//   in_data
//   out_valid/out_ready result output handshake
//   out_data, out_sat   rounded/saturated result and clamp flag
//   busy                high whenever a run or result is in progress
//
// state  | meaning
// IDLE   | waiting for start with non-zero vec_count
// ACCUM  | accepting partial sums until vec_count beats are seen
// RESULT | result held on out_data until downstream accepts it
module vsq_accumulator
  import vsq_pkg::*;
#(
  parameter int IN_W  = VSQ_PSUM_W,
  parameter int CNT_W = 8,
  parameter int ACC_W = VSQ_ACC_W,
  parameter int OUT_W = VSQ_OUT_W,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_count,
  input  logic [SH_W-1:0]  shift,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  vsq_state_e       state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [SH_W-1:0]  shift_q;
  logic             start_ok;
  logic             load;
  logic             beat;
  logic             last_beat;
  logic [OUT_W-1:0] res_r;
  logic             res_sat;

  // handshake outputs depend only on state
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == RESULT);
  assign busy      = (state != IDLE);

  assign start_ok  = start && (vec_count != '0);
  assign beat      = in_valid && in_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = beat && (cnt_inc == vec_cnt_q);
  assign acc_next  = acc + {{(ACC_W-IN_W){1'b0}}, in_data};

  // the final sum includes the last beat, so round from acc_next
  vsq_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_round_sat (
    .s     (acc_next),
    .shift (shift_q),
    .r     (res_r),
    .sat   (res_sat)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = ACCUM;
          load       = 1'b1;
        end
      end
      ACCUM: begin
        if (last_beat) state_next = RESULT;
      end
      RESULT: begin
        if (out_ready) begin
          if (start_ok) begin
            state_next = ACCUM;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      vec_cnt_q <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        vec_cnt_q <= vec_count;
        shift_q   <= shift;
        acc       <= '0;
        cnt       <= '0;
      end else if (beat) begin
        acc <= acc_next;
        cnt <= cnt_inc;
      end
      if (last_beat) begin
        out_data <= res_r;
        out_sat  <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_vsq_accumulator.sv
module tb_vsq_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vec_count;
  logic [4:0]  shift;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q[$];

  typedef struct {
    logic [7:0]       vc;
    logic [4:0]       sh;
    logic [3:0][23:0] b;
    int               gap;
    logic [15:0]      d;
    logic             s;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  vsq_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_count (vec_count),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // caller sits at posedge+1; accepts the pending result and scores it
  task automatic do_ack();
    logic [16:0] e;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ack_valid", 32'(out_valid), 32'd1);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: result 0x%0h with nothing expected", out_data);
    end else begin
      e = exp_q.pop_front();
      if ({out_sat, out_data} !== e) begin
        n_fail++;
        $display("FAIL result: got data 0x%0h sat %0d expected data 0x%0h sat %0d",
                 out_data, out_sat, e[15:0], e[16]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input vec_t v, input bit ack);
    start     = 1'b1;
    vec_count = v.vc;
    shift     = v.sh;
    exp_q.push_back({v.s, v.d});
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'(v.vc); i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          in_valid = 1'b0;
          in_data  = 24'hABCDEF;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v.b[i];
      @(negedge clk);
      chk("early_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("valid_latency", 32'(out_valid), 32'd1);
    chk("in_ready_result", 32'(in_ready), 32'd0);
    if (ack) do_ack();
  endtask

  initial begin
    vecs[0]  = '{8'd3, 5'd0,  {24'd0, 24'd30, 24'd20, 24'd10},              0, 16'd60,    1'b0};
    vecs[1]  = '{8'd2, 5'd2,  {24'd0, 24'd0, 24'd6, 24'd5},                 3, 16'd3,     1'b0};
    vecs[2]  = '{8'd1, 5'd0,  {24'd0, 24'd0, 24'd0, 24'h0FFFFF},            0, 16'hFFFF,  1'b1};
    vecs[3]  = '{8'd1, 5'd4,  {24'd0, 24'd0, 24'd0, 24'h0FFFFF},            0, 16'hFFFF,  1'b1};
    vecs[4]  = '{8'd1, 5'd5,  {24'd0, 24'd0, 24'd0, 24'h0FFFFF},            0, 16'h8000,  1'b0};
    vecs[5]  = '{8'd4, 5'd1,  {24'd4, 24'd3, 24'd2, 24'd1},                 1, 16'd5,     1'b0};
    vecs[6]  = '{8'd2, 5'd0,  {24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF},       1, 16'hFFFF,  1'b1};
    vecs[7]  = '{8'd3, 5'd8,  {24'd0, 24'h00007F, 24'h000080, 24'h000100},  0, 16'd2,     1'b0};
    vecs[8]  = '{8'd1, 5'd16, {24'd0, 24'd0, 24'd0, 24'hFFFF80},            0, 16'h0100,  1'b0};
    vecs[9]  = '{8'd2, 5'd0,  {24'd0, 24'd0, 24'h007FFF, 24'h008000},       0, 16'hFFFF,  1'b0};
    vecs[10] = '{8'd2, 5'd0,  {24'd0, 24'd0, 24'h008000, 24'h008000},       2, 16'hFFFF,  1'b1};

    rst = 1'b1; start = 1'b0; vec_count = '0; shift = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);

    for (int k = 0; k < 11; k++) run(vecs[k], 1'b1);

    // start with vec_count == 0 is ignored, in_valid ignored in IDLE
    start = 1'b1; vec_count = 8'd0; in_valid = 1'b1; in_data = 24'd99;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_cnt_busy", 32'(busy), 32'd0);
    chk("zero_cnt_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("zero_cnt_idle", 32'(busy), 32'd0);

    // pending result with back-pressure, then back-to-back restart
    run('{8'd1, 5'd0, {24'd0, 24'd0, 24'd0, 24'd100}, 0, 16'd100, 1'b0}, 1'b0);
    in_valid = 1'b1; in_data = 24'd55;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_data", 32'(out_data), 32'd100);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b1; vec_count = 8'd1; shift = 5'd0;
    exp_q.push_back({1'b0, 16'd7});
    do_ack();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    in_data = 24'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    do_ack();

    // reset mid-run discards partial sum
    start = 1'b1; vec_count = 8'd4; shift = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 24'd1;
    @(posedge clk); #1;
    in_data = 24'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_sat", 32'(out_sat), 32'd0);
    run('{8'd2, 5'd0, {24'd0, 24'd0, 24'd8, 24'd7}, 0, 16'd15, 1'b0}, 1'b1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
